i8085_int_ctrl: RTL and testbench

Interrupt controller and arbiter for the 8085 core. It synchronises the five interrupt pins (TRAP, RST7.5, RST6.5, RST5.5, INTR) and applies SIM masking and the INTE flag. At each instruction boundary it grants the highest-priority pending request to the core's control sequencer and holds a vector until the core acknowledges. It also implements the SIM/RIM register semantics, including the serial SID/SOD bits.

---
 rtl/i8085_int_ctrl_if.sv | 43 ++++
 rtl/i8085_int_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_i8085_int_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/i8085_int_ctrl_if.sv
// ---------------------------------------------------------------------------
// i8085_int_ctrl_if
// Bundles the signals between the 8085 control sequencer / pins and the
// interrupt controller.
//   master : the core side (drives pins, strobes and accumulator; reads grant)
//   slave  : the interrupt controller itself
// Pins       : trap, rst75, rst65, rst55, intr, sid (asynchronous)
// Core->ctrl : instr_boundary, sim_we, acc[7:0], rim_re, ei, di, inta_ack
// Ctrl->core : irq_req, irq_vector[15:0], irq_is_intr, inte, rim_data[7:0], sod
// ---------------------------------------------------------------------------
interface i8085_int_ctrl_if;
    logic        trap;
    logic        rst75;
    logic        rst65;
    logic        rst55;
    logic        intr;
    logic        sid;
    logic        instr_boundary;
    logic        sim_we;
    logic [7:0]  acc;
    logic        rim_re;
    logic        ei;
    logic        di;
    logic        inta_ack;
    logic        irq_req;
    logic [15:0] irq_vector;
    logic        irq_is_intr;
    logic        inte;
    logic [7:0]  rim_data;
    logic        sod;

    modport master (
        output trap, rst75, rst65, rst55, intr, sid,
        output instr_boundary, sim_we, acc, rim_re, ei, di, inta_ack,
        input  irq_req, irq_vector, irq_is_intr, inte, rim_data, sod
    );

    modport slave (
        input  trap, rst75, rst65, rst55, intr, sid,
        input  instr_boundary, sim_we, acc, rim_re, ei, di, inta_ack,
        output irq_req, irq_vector, irq_is_intr, inte, rim_data, sod
    );
endinterface

// File: rtl/i8085_int_ctrl.sv
// ---------------------------------------------------------------------------
// i8085_int_ctrl
// Interrupt controller / arbiter for the 8085 core. Synchronises the five
// interrupt pins, applies SIM masks and INTE, grants the highest-priority
// request at an instruction boundary and holds it until the core acks.
// Implements SIM/RIM semantics including the serial SID/SOD bits.
//
// Parameter : SYNC_STAGES (>= 2) synchroniser depth on every async pin.
// Ports     : clk_out   - CPU clock
//             resetn_in - asynchronous active-low reset
//             bus       - i8085_int_ctrl_if.slave (pins, core strobes, grant)
// Macro     : I8085_SERIAL_EN - when defined, SID is synchronised into
//             rim_data[7] and SIM SOE/SOD drive sod; otherwise rim_data[7]
//             and sod are tied low and acc[7:6] are ignored on SIM.
// ---------------------------------------------------------------------------
module i8085_int_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk_out,
    input  logic            resetn_in,
    i8085_int_ctrl_if.slave bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Pin vector order: [4]=TRAP [3]=RST7.5 [2]=RST6.5 [1]=RST5.5 [0]=INTR
    logic [SYNC_STAGES-1:0][4:0] pin_sync_q;
    logic [4:0]  pin_raw_s, pin_s, pin_prev_q, pin_rise_s;

    state_e      state_q, state_d;
    logic        irq_req_q, irq_req_d;
    logic [15:0] vec_q, vec_d;
    logic        is_intr_q, is_intr_d;
    logic        win_trap_q, win_trap_d;
    logic        win_75_q, win_75_d;
    logic        inte_q, inte_d;
    logic        ei_pend_q, ei_pend_d;
    logic [2:0]  mask_q, mask_d;
    logic        p75_q, p75_d;
    logic        trap_lat_q, trap_lat_d;
    logic        trap_seen_q, trap_seen_d;
    logic        ie_saved_q, ie_saved_d;
    logic        sod_q, sod_d;
    logic        sid_s;
    logic        unused_acc_s;

    logic        ack_s;
    logic [4:0]  elig_s;
    logic [15:0] win_vec_s;
    logic        win_intr_s, win_trap_s, win_75_s;

    assign pin_raw_s  = {bus.trap, bus.rst75, bus.rst65, bus.rst55, bus.intr};
    assign pin_s      = pin_sync_q[SYNC_STAGES-1];
    assign pin_rise_s = pin_s & ~pin_prev_q;

`ifdef I8085_SERIAL_EN
    logic [SYNC_STAGES-1:0] sid_sync_q;

    // SID synchroniser chain
    always_ff @(posedge clk_out or negedge resetn_in) begin
        if (!resetn_in) begin
            sid_sync_q <= '0;
        end else begin
            sid_sync_q <= {sid_sync_q[SYNC_STAGES-2:0], bus.sid};
        end
    end

    assign sid_s        = sid_sync_q[SYNC_STAGES-1];
    assign unused_acc_s = bus.acc[5];
`else
    assign sid_s        = 1'b0;
    assign unused_acc_s = ^{bus.acc[7:5], bus.sid};
`endif

    // Interrupt pin synchronisers plus previous-cycle copy for edge detection
    always_ff @(posedge clk_out or negedge resetn_in) begin
        if (!resetn_in) begin
            pin_sync_q <= '0;
            pin_prev_q <= 5'b00000;
        end else begin
            pin_sync_q <= {pin_sync_q[SYNC_STAGES-2:0], pin_raw_s};
            pin_prev_q <= pin_s;
        end
    end

    // Only an ack during GRANT is meaningful; stray acks in IDLE are ignored
    assign ack_s = (state_q == GRANT) && bus.inta_ack;

    // Eligibility per source and fixed-priority winner selection
    always_comb begin
        elig_s[4]  = trap_lat_q & pin_s[4];
        elig_s[3]  = inte_q & ~mask_q[2] & p75_q;
        elig_s[2]  = inte_q & ~mask_q[1] & pin_s[2];
        elig_s[1]  = inte_q & ~mask_q[0] & pin_s[1];
        elig_s[0]  = inte_q & pin_s[0];
        win_vec_s  = 16'h0000;
        win_intr_s = 1'b0;
        win_trap_s = 1'b0;
        win_75_s   = 1'b0;
        if (elig_s[4]) begin
            win_vec_s  = 16'h0024;
            win_trap_s = 1'b1;
        end else if (elig_s[3]) begin
            win_vec_s = 16'h003C;
            win_75_s  = 1'b1;
        end else if (elig_s[2]) begin
            win_vec_s = 16'h0034;
        end else if (elig_s[1]) begin
            win_vec_s = 16'h002C;
        end else if (elig_s[0]) begin
            win_intr_s = 1'b1;
        end else begin
            win_vec_s = 16'h0000;
        end
    end

    // Next-state logic: source latches, SIM, INTE, arbiter FSM
    always_comb begin
        state_d     = state_q;
        irq_req_d   = irq_req_q;
        vec_d       = vec_q;
        is_intr_d   = is_intr_q;
        win_trap_d  = win_trap_q;
        win_75_d    = win_75_q;
        trap_seen_d = trap_seen_q;
        ie_saved_d  = ie_saved_q;
        sod_d       = sod_q;

        // A new edge always beats a clear in the same cycle
        if (pin_rise_s[4]) begin
            trap_lat_d = 1'b1;
        end else if (ack_s && win_trap_q) begin
            trap_lat_d = 1'b0;
        end else begin
            trap_lat_d = trap_lat_q;
        end

        if (pin_rise_s[3]) begin
            p75_d = 1'b1;
        end else if ((ack_s && win_75_q) || (bus.sim_we && bus.acc[4])) begin
            p75_d = 1'b0;
        end else begin
            p75_d = p75_q;
        end

        if (bus.sim_we && bus.acc[3]) begin
            mask_d = bus.acc[2:0];
        end else begin
            mask_d = mask_q;
        end

`ifdef I8085_SERIAL_EN
        if (bus.sim_we && bus.acc[6]) begin
            sod_d = bus.acc[7];
        end else begin
            sod_d = sod_q;
        end
`endif

        // EI takes effect one instruction late; DI and ack clear immediately
        if (bus.di) begin
            inte_d    = 1'b0;
            ei_pend_d = 1'b0;
        end else begin
            if (bus.ei) begin
                ei_pend_d = 1'b1;
            end else if (bus.instr_boundary) begin
                ei_pend_d = 1'b0;
            end else begin
                ei_pend_d = ei_pend_q;
            end
            if (ack_s) begin
                inte_d = 1'b0;
            end else if (bus.instr_boundary && ei_pend_q) begin
                inte_d = 1'b1;
            end else begin
                inte_d = inte_q;
            end
        end

        // TRAP ack snapshots INTE so RIM can report the pre-trap state
        if (ack_s && win_trap_q) begin
            trap_seen_d = 1'b1;
            ie_saved_d  = inte_q;
        end else if (bus.rim_re) begin
            trap_seen_d = 1'b0;
        end else begin
            trap_seen_d = trap_seen_q;
        end

        case (state_q)
            IDLE: begin
                if (bus.instr_boundary && !bus.inta_ack && (|elig_s)) begin
                    state_d    = GRANT;
                    irq_req_d  = 1'b1;
                    vec_d      = win_vec_s;
                    is_intr_d  = win_intr_s;
                    win_trap_d = win_trap_s;
                    win_75_d   = win_75_s;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                // Grant is held even if its source drops; no preemption
                if (bus.inta_ack) begin
                    state_d    = IDLE;
                    irq_req_d  = 1'b0;
                    vec_d      = 16'h0000;
                    is_intr_d  = 1'b0;
                    win_trap_d = 1'b0;
                    win_75_d   = 1'b0;
                end else begin
                    state_d = GRANT;
                end
            end
            default: begin
                state_d   = IDLE;
                irq_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_out or negedge resetn_in) begin
        if (!resetn_in) begin
            state_q     <= IDLE;
            irq_req_q   <= 1'b0;
            vec_q       <= 16'h0000;
            is_intr_q   <= 1'b0;
            win_trap_q  <= 1'b0;
            win_75_q    <= 1'b0;
            inte_q      <= 1'b0;
            ei_pend_q   <= 1'b0;
            mask_q      <= 3'b111;
            p75_q       <= 1'b0;
            trap_lat_q  <= 1'b0;
            trap_seen_q <= 1'b0;
            ie_saved_q  <= 1'b0;
            sod_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            irq_req_q   <= irq_req_d;
            vec_q       <= vec_d;
            is_intr_q   <= is_intr_d;
            win_trap_q  <= win_trap_d;
            win_75_q    <= win_75_d;
            inte_q      <= inte_d;
            ei_pend_q   <= ei_pend_d;
            mask_q      <= mask_d;
            p75_q       <= p75_d;
            trap_lat_q  <= trap_lat_d;
            trap_seen_q <= trap_seen_d;
            ie_saved_q  <= ie_saved_d;
            sod_q       <= sod_d;
        end
    end

    assign bus.irq_req     = irq_req_q;
    assign bus.irq_vector  = vec_q;
    assign bus.irq_is_intr = is_intr_q;
    assign bus.inte        = inte_q;
    assign bus.sod         = sod_q;
    assign bus.rim_data    = {sid_s, p75_q, pin_s[2], pin_s[1],
                              (trap_seen_q ? ie_saved_q : inte_q), mask_q};

endmodule

// File: tb/tb_i8085_int_ctrl.sv
// ---------------------------------------------------------------------------
// tb_i8085_int_ctrl
// Directed scenarios followed by a randomized run. A behavioural model
// (pin history queue + source/INTE/grant bookkeeping) predicts every output
// after every clock; directed steps additionally check literal values.
// ---------------------------------------------------------------------------
module tb_i8085_int_ctrl;
    localparam int S = 2;
`ifdef I8085_SERIAL_EN
    localparam bit SERIAL = 1'b1;
`else
    localparam bit SERIAL = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    i8085_int_ctrl_if bus ();

    i8085_int_ctrl #(.SYNC_STAGES(S)) dut (
        .clk_out   (clk),
        .resetn_in (rst_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // Model state. History bits: [5]=sid [4]=trap [3]=7.5 [2]=6.5 [1]=5.5 [0]=intr
    bit [5:0]  hist[$];
    bit        m_trap, m_p75, m_inte, m_eip, m_ies, m_ts, m_sod, m_granted, m_intr;
    bit [2:0]  m_mask;
    bit [15:0] m_vec;
    int        m_src;
    bit [15:0] vec_tab [5] = '{16'h0024, 16'h003C, 16'h0034, 16'h002C, 16'h0000};

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < S + 1; i++) hist.push_back(6'd0);
        m_trap = 1'b0; m_p75 = 1'b0; m_inte = 1'b0; m_eip = 1'b0;
        m_ies = 1'b0; m_ts = 1'b0; m_sod = 1'b0; m_granted = 1'b0;
        m_intr = 1'b0; m_mask = 3'b111; m_vec = 16'h0000; m_src = -1;
    endtask

    // Advance the model by one clock using the inputs present at that edge
    task automatic model_step();
        bit [5:0] s, p, rise;
        bit [4:0] elig;
        bit       ack, n_inte, n_eip;
        int       win;
        int       sz;
        sz   = hist.size();
        s    = hist[sz-S];
        p    = hist[sz-S-1];
        rise = s & ~p;
        ack  = m_granted && bus.inta_ack;
        elig[0] = m_trap && s[4];
        elig[1] = m_inte && !m_mask[2] && m_p75;
        elig[2] = m_inte && !m_mask[1] && s[2];
        elig[3] = m_inte && !m_mask[0] && s[1];
        elig[4] = m_inte && s[0];
        win = -1;
        for (int i = 4; i >= 0; i--) if (elig[i]) win = i;

        if (bus.di) begin
            n_inte = 1'b0; n_eip = 1'b0;
        end else begin
            n_eip  = bus.ei ? 1'b1 : (bus.instr_boundary ? 1'b0 : m_eip);
            n_inte = ack ? 1'b0 : ((bus.instr_boundary && m_eip) ? 1'b1 : m_inte);
        end
        if (ack && m_src == 0) begin
            m_ts = 1'b1; m_ies = m_inte;
        end else if (bus.rim_re) begin
            m_ts = 1'b0;
        end
        if (rise[4]) m_trap = 1'b1;
        else if (ack && m_src == 0) m_trap = 1'b0;
        if (rise[3]) m_p75 = 1'b1;
        else if ((ack && m_src == 1) || (bus.sim_we && bus.acc[4])) m_p75 = 1'b0;
        if (bus.sim_we && bus.acc[3]) m_mask = bus.acc[2:0];
        if (SERIAL && bus.sim_we && bus.acc[6]) m_sod = bus.acc[7];

        if (m_granted) begin
            if (bus.inta_ack) begin
                m_granted = 1'b0; m_vec = 16'h0000; m_intr = 1'b0; m_src = -1;
            end
        end else if (bus.instr_boundary && !bus.inta_ack && win >= 0) begin
            m_granted = 1'b1; m_vec = vec_tab[win]; m_intr = (win == 4); m_src = win;
        end
        m_inte = n_inte;
        m_eip  = n_eip;

        hist.push_back({bus.sid, bus.trap, bus.rst75, bus.rst65, bus.rst55, bus.intr});
        if (hist.size() > S + 2) void'(hist.pop_front());
    endtask

    task automatic compare_model();
        bit [5:0] s;
        bit [7:0] rim;
        s   = hist[hist.size()-S];
        rim = {SERIAL ? s[5] : 1'b0, m_p75, s[2], s[1], (m_ts ? m_ies : m_inte), m_mask};
        check("m_irq_req", bus.irq_req, {15'd0, m_granted});
        check("m_vector",  bus.irq_vector, m_vec);
        check("m_is_intr", bus.irq_is_intr, {15'd0, m_intr});
        check("m_inte",    bus.inte, {15'd0, m_inte});
        check("m_rim",     bus.rim_data, {8'd0, rim});
        check("m_sod",     bus.sod, {15'd0, m_sod});
    endtask

    task automatic clear_strobes();
        bus.instr_boundary = 1'b0; bus.sim_we = 1'b0; bus.rim_re = 1'b0;
        bus.ei = 1'b0; bus.di = 1'b0; bus.inta_ack = 1'b0; bus.acc = 8'h00;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
        compare_model();
        clear_strobes();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_ei();       bus.ei = 1'b1;             step(); endtask
    task automatic do_boundary(); bus.instr_boundary = 1'b1; step(); endtask
    task automatic do_ack();      bus.inta_ack = 1'b1;       step(); endtask
    task automatic do_sim(input logic [7:0] a);
        bus.sim_we = 1'b1; bus.acc = a; step();
    endtask

    initial begin
        checks = 0; errors = 0;
        clk = 1'b0; rst_n = 1'b0;
        bus.trap = 1'b0; bus.rst75 = 1'b0; bus.rst65 = 1'b0; bus.rst55 = 1'b0;
        bus.intr = 1'b0; bus.sid = 1'b0;
        clear_strobes();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_irq_req", bus.irq_req, 16'h0000);
        check("rst_vector",  bus.irq_vector, 16'h0000);
        check("rst_is_intr", bus.irq_is_intr, 16'h0000);
        check("rst_inte",    bus.inte, 16'h0000);
        check("rst_sod",     bus.sod, 16'h0000);
        rst_n = 1'b1;
        model_reset();

        // Reset defaults seen through RIM
        bus.rim_re = 1'b1; step();
        check("rim_default", bus.rim_data, 16'h0007);

        // Priority: 6.5 beats 5.5
        do_ei(); do_sim(8'h08); do_boundary();
        check("inte_on", bus.inte, 16'h0001);
        bus.rst55 = 1'b1; bus.rst65 = 1'b1; steps(3);
        do_boundary();
        check("prio_req", bus.irq_req, 16'h0001);
        check("prio_vec", bus.irq_vector, 16'h0034);
        do_ack();
        check("prio_ack_req",  bus.irq_req, 16'h0000);
        check("prio_ack_inte", bus.inte, 16'h0000);
        bus.rst55 = 1'b0; bus.rst65 = 1'b0; steps(3);

        // RST7.5 edge latched with INTE off, then cleared by SIM R7.5
        bus.rst75 = 1'b1; step(); bus.rst75 = 1'b0; steps(3);
        check("p75_latched", bus.rim_data[6], 16'h0001);
        do_sim(8'h10);
        check("p75_cleared", bus.rim_data[6], 16'h0000);

        // TRAP with INTE set, ie_saved/trap_seen through RIM
        do_ei(); do_boundary();
        bus.trap = 1'b1; steps(3);
        do_boundary();
        check("trap_req", bus.irq_req, 16'h0001);
        check("trap_vec", bus.irq_vector, 16'h0024);
        do_ack();
        check("trap_inte", bus.inte, 16'h0000);
        check("trap_rim_ie_saved", bus.rim_data[3], 16'h0001);
        bus.rim_re = 1'b1; step();
        check("trap_rim_ie_live", bus.rim_data[3], 16'h0000);
        bus.trap = 1'b0; steps(3);

        // EI delay: first boundary after EI grants nothing
        bus.rst55 = 1'b1; steps(3);
        do_ei();
        do_boundary();
        check("ei_delay_none", bus.irq_req, 16'h0000);
        do_boundary();
        check("ei_delay_req", bus.irq_req, 16'h0001);
        check("ei_delay_vec", bus.irq_vector, 16'h002C);
        do_ack();
        bus.rst55 = 1'b0; steps(3);

        // INTR grant and SOD
        do_ei(); do_boundary();
        bus.intr = 1'b1; steps(3);
        do_boundary();
        check("intr_req",  bus.irq_req, 16'h0001);
        check("intr_flag", bus.irq_is_intr, 16'h0001);
        check("intr_vec",  bus.irq_vector, 16'h0000);
        do_ack();
        do_sim(8'hC0);
        check("sod_set", bus.sod, SERIAL ? 16'h0001 : 16'h0000);

        // Reset during GRANT drops irq_req without waiting for a clock
        do_ei(); do_boundary(); do_boundary();
        check("mid_grant_req", bus.irq_req, 16'h0001);
        #3;
        rst_n = 1'b0;
        bus.intr = 1'b0;
        #1;
        check("async_rst_req",  bus.irq_req, 16'h0000);
        check("async_rst_inte", bus.inte, 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 7) == 0) bus.trap  = ~bus.trap;
            if ($urandom_range(0, 5) == 0) bus.rst75 = ~bus.rst75;
            if ($urandom_range(0, 7) == 0) bus.rst65 = ~bus.rst65;
            if ($urandom_range(0, 7) == 0) bus.rst55 = ~bus.rst55;
            if ($urandom_range(0, 7) == 0) bus.intr  = ~bus.intr;
            bus.sid            = $urandom_range(0, 1) == 1;
            bus.instr_boundary = $urandom_range(0, 2) == 0;
            bus.sim_we         = $urandom_range(0, 11) == 0;
            bus.acc            = 8'($urandom_range(0, 255));
            bus.rim_re         = $urandom_range(0, 7) == 0;
            bus.ei             = $urandom_range(0, 6) == 0;
            bus.di             = $urandom_range(0, 19) == 0;
            bus.inta_ack       = m_granted ? ($urandom_range(0, 2) == 0)
                                           : ($urandom_range(0, 19) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
